// File: rtl/bin_bcd_seq.sv
// rtl/bin_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module bin_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_pend;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_neg;
    logic               r_valid;

    logic [BIN_W-1:0]   w_mag;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W-1:0]   w_next;

    // Most negative input wraps to 2^(BIN_W-1), which still fits the unsigned magnitude.
    always_comb begin
        w_mag = bin;
        if (signed_mode && bin[BIN_W-1]) begin
            w_mag = ~bin + BIN_W'(1);
        end
    end

    // All digits are corrected from the same snapshot, then the whole register shifts once.
    always_comb begin
        w_corr = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[4*k +: 4] >= 4'd5) begin
                w_corr[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
            end else begin
                w_corr[4*k +: 4] = r_work[4*k +: 4];
            end
        end
        w_next = (w_corr << 1) | BCD_W'(r_shift[BIN_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_neg_pend <= 1'b0;
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift    <= w_mag;
                        r_neg_pend <= signed_mode & bin[BIN_W-1];
                        r_work     <= '0;
                        r_cnt      <= CNT_INIT;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_work  <= w_next;
                    r_shift <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_next;
                        r_neg   <= r_neg_pend;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign valid = r_valid;
    assign bcd   = r_bcd;
    assign neg   = r_neg;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb/tb_bin_bcd_seq.sv - randomized self-checking bench for bin_bcd_seq against a behavioural model
module tb_bin_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [9:0]  bin;
    logic        ready;
    logic        valid;
    logic [15:0] bcd;
    logic        neg;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int fail_cnt = 0;
    logic chk_en = 1'b0;

    bin_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .bin         (bin),
        .ready       (ready),
        .valid       (valid),
        .bcd         (bcd),
        .neg         (neg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            if (fail_cnt <= 40) begin
                $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
            end
        end
    endtask

    function automatic int mag_of(input logic [9:0] b, input logic sm);
        if (sm && b[9]) return 1024 - int'(b);
        return int'(b);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: a request accepted while idle completes exactly 10 edges later.
    int          cyc = 0;
    int          m_done;
    logic        m_busy;
    logic        m_valid;
    logic [15:0] m_bcd, m_pend_bcd;
    logic        m_neg, m_pend_neg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_neg   <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy     <= 1'b1;
                    m_done     <= cyc + 10;
                    m_pend_bcd <= to_bcd(mag_of(bin, signed_mode));
                    m_pend_neg <= signed_mode && bin[9];
                end
            end else if (cyc == m_done) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_bcd   <= m_pend_bcd;
                m_neg   <= m_pend_neg;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("cyc_ready", {31'd0, ready}, {31'd0, !m_busy});
            chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("cyc_bcd",   {16'd0, bcd},   {16'd0, m_bcd});
            chk("cyc_neg",   {31'd0, neg},   {31'd0, m_neg});
        end
    end

    task automatic conv(input logic [9:0] b, input logic sm, input logic [15:0] eb,
                        input logic en, input string nm);
        int lat;
        logic got;
        start = 1'b1; bin = b; signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (valid) got = 1'b1;
        end
        chk({nm, "_lat"}, lat, 10);
        chk({nm, "_bcd"}, {16'd0, bcd}, {16'd0, eb});
        chk({nm, "_neg"}, {31'd0, neg}, {31'd0, en});
        @(posedge clk); #1;
        chk({nm, "_pulse"}, {31'd0, valid}, 32'd0);
    endtask

    logic [9:0]  u_in  [7] = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd512, 10'd999, 10'd1023};
    logic [15:0] u_exp [7] = '{16'h0000, 16'h0009, 16'h0010, 16'h0099, 16'h0512, 16'h0999, 16'h1023};
    logic [9:0]  s_in  [4] = '{10'h3FF, 10'h200, 10'h1FF, 10'h000};
    logic [15:0] s_exp [4] = '{16'h0001, 16'h0512, 16'h0511, 16'h0000};
    logic        s_neg [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        logic got;
        logic seen;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; bin = '0;

        chk("model_1023",   {16'd0, to_bcd(mag_of(10'h3FF, 1'b0))}, 32'h1023);
        chk("model_neg1",   {16'd0, to_bcd(mag_of(10'h3FF, 1'b1))}, 32'h0001);
        chk("model_minneg", {16'd0, to_bcd(mag_of(10'h200, 1'b1))}, 32'h0512);
        chk("model_456",    {16'd0, to_bcd(mag_of(10'd456, 1'b0))}, 32'h0456);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_bcd",   {16'd0, bcd},   32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) conv(u_in[i], 1'b0, u_exp[i], 1'b0, "unsigned");
        for (int i = 0; i < 4; i++) conv(s_in[i], 1'b1, s_exp[i], s_neg[i], "signed");

        // Asynchronous reset mid-cycle while bcd holds 0x0000 from last result; reload a value first.
        conv(10'd999, 1'b0, 16'h0999, 1'b0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_bcd",   {16'd0, bcd},   32'd0);
        chk("arst_neg",   {31'd0, neg},   32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // start held high with changing operand: only the first operand is converted.
        start = 1'b1; bin = 10'd77; signed_mode = 1'b0;
        @(posedge clk); #1;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            bin = 10'($urandom); signed_mode = 1'($urandom);
            @(posedge clk); #1;
            n++;
            if (valid) got = 1'b1;
        end
        start = 1'b0;
        chk("hold_lat", n, 10);
        chk("hold_bcd", {16'd0, bcd}, 32'h0077);

        // start raised in the valid cycle.
        start = 1'b1; bin = 10'd500; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1; n++;
            if (valid) got = 1'b1;
        end
        chk("b2b_first", {16'd0, bcd}, 32'h0500);
        start = 1'b1; bin = 10'd123;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1; n++;
            start = 1'b0;
            if (valid) got = 1'b1;
        end
        chk("b2b_gap", n, 11);
        chk("b2b_bcd", {16'd0, bcd}, 32'h0123);

        // Abort after 4 shifts of 1023.
        start = 1'b1; bin = 10'd1023; signed_mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_bcd",   {16'd0, bcd},   32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        chk("abort_novalid", {31'd0, seen}, 32'd0);
        conv(10'd456, 1'b0, 16'h0456, 1'b0, "after_abort");

        // All inputs in both modes with random gaps and ignored requests during conversion.
        for (int sm = 0; sm < 2; sm++) begin
            for (int v = 0; v < 1024; v++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                start = 1'b1; bin = 10'(v); signed_mode = 1'(sm);
                @(posedge clk); #1;
                n = 0; got = 1'b0;
                while (n < 20 && !got) begin
                    start = 1'($urandom); bin = 10'($urandom); signed_mode = 1'($urandom);
                    @(posedge clk); #1; n++;
                    if (valid) got = 1'b1;
                end
                start = 1'b0;
                if (!got) chk("exh_timeout", 32'd0, 32'd1);
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/bin_bcd_seq.md
# bin_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between the binary datapath (counters, ADC and measurement values) and the 7-segment display drivers. It replaces single-cycle combinational conversion where operand width makes a combinational chain too deep. Adds a start/ready/valid handshake and an optional two's-complement input mode with a separate sign flag.

## Interface
- BIN_W, 10, binary operand width in bits; legal range 4..32.
- DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W − 1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only when ready=1.
- signed_mode  in  1  1 = bin is two's complement, 0 = unsigned; sampled with start.
- bin  in  BIN_W  operand; sampled with start.
- ready  out  1  1 = idle, start accepted this cycle.
- valid  out  1  one-cycle pulse: bcd/neg hold a new result.
- bcd  out  4*DIGITS  result; digit k occupies bits [4k+3:4k], digit 0 least significant.
- neg  out  1  1 = result is negative; meaningful only for signed_mode=1.

## Operation
- FSM states: IDLE, CONV.
- IDLE:
  - ready=1.
  - On start=1, capture the operand magnitude into a BIN_W shift register.
  - Magnitude is bin when signed_mode=0 or bin[BIN_W-1]=0; otherwise it is (~bin + 1), taken modulo 2^BIN_W.
  - Capture neg_pending = signed_mode & bin[BIN_W-1].
  - Clear the working BCD register to 0, load bit counter = BIN_W, go to CONV.
- CONV:
  - ready=0.
  - Each cycle, every 4-bit digit of the working register ≥5 gets +3. The digits are corrected in parallel, all from the same pre-correction snapshot.
  - The corrected working register is then shifted left by 1. The shift-register MSB enters at bit 0, the shift register shifts left, and the counter decrements.
  - When the counter reaches 1, that cycle's shift is the last one. On that edge, load bcd and neg from the final working value, assert valid, and go to IDLE.
- Width rules:
  - The working register is 4*DIGITS bits.
  - Bits shifted past the top digit are discarded. They are never nonzero when the DIGITS constraint holds.
  - Most negative input −2^(BIN_W−1) converts to magnitude 2^(BIN_W−1), with no overflow.
- neg is 0 for a zero input in every mode.
- bcd and neg hold their last result until the next completion. They never show intermediate values.
- start while ready=0 is ignored; there is no queueing. bin and signed_mode may change freely during CONV.

## Timing
- Reset values: state=IDLE, ready=1, valid=0, bcd=0, neg=0, working registers 0.
- Reset is asynchronous and takes effect immediately. Reset mid-conversion aborts the conversion: no valid pulse, bcd and neg return to 0.
- Latency:
  - start is sampled high at edge E0.
  - Shifts occur at edges E1..E_BIN_W.
  - At E_BIN_W, valid=1, bcd/neg update, and ready=1.
  - valid drops at E_BIN_W+1 unless a new conversion also completes then, which cannot happen.
  - Result latency is therefore BIN_W edges after the accepting edge.
- Back-to-back: start high in the valid cycle is accepted at E_BIN_W+1. Sustained throughput is one result per BIN_W+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs except none. ready is decoded from state only.

## Test plan
All scenarios use BIN_W=10, DIGITS=4.
- Reset: rst_n low mid-cycle → ready=1, valid=0, bcd=0x0000, neg=0 asynchronously, before the next edge.
- Unsigned sweep: start with signed_mode=0 and bin = 0, 9, 10, 99, 512, 999, 1023 → bcd = 0x0000, 0x0009, 0x0010, 0x0099, 0x0512, 0x0999, 0x1023, all with neg=0. valid is exactly one cycle wide, exactly 10 edges after the accepting edge.
- Signed mode:
  - bin=10'h3FF → bcd=0x0001, neg=1.
  - bin=10'h200 → bcd=0x0512, neg=1.
  - bin=10'h1FF → bcd=0x0511, neg=0.
  - bin=0 → bcd=0x0000, neg=0.
- Handshake:
  - start held high with changing bin during CONV → only the first operand is converted.
  - start raised in the valid cycle → second result (bin 123 → 0x0123) appears 11 cycles after the first valid.
- Abort: rst_n pulsed low after 4 shifts of a 1023 conversion → no valid, bcd=0x0000. A following conversion of 456 → 0x0456 with correct latency.
- Exhaustive: all 1024 inputs in both modes are compared against a reference model; bcd holds its value between valid pulses.
